apb_cmd_master: RTL and testbench
=================================

Name: apb_cmd_master

Overview:
- Upstream APB master stage for the DMA harness register bus; drives the APB pins the APB agent interface monitors and checks.
- Accepts single register commands on a valid/ready port and runs each as one APB SETUP/ACCESS transfer.
- Honours PREADY wait states, captures PRDATA and PSLVERR, and returns one response per command on a valid/ready response port.
- A watchdog aborts transfers that stall too long.

Parameters:
ADDR_WIDTH, 32, APB address width
DATA_WIDTH, 32, APB data width
TIMEOUT_CYCLES, 256, enabled ACCESS cycles without pready before abort; 0 disables the watchdog

Ports:
pclk  input  1  APB clock, all logic on rising edge
presetn  input  1  asynchronous active-low reset
pclken  input  1  APB clock enable; APB-side state advances only when 1
cmd_valid  input  1  command request
cmd_ready  output  1  command accepted when cmd_valid && cmd_ready
cmd_write  input  1  1 = write, 0 = read
cmd_addr  input  ADDR_WIDTH  target address
cmd_wdata  input  DATA_WIDTH  write data
rsp_valid  output  1  response available
rsp_ready  input  1  response consumed when rsp_valid && rsp_ready
rsp_rdata  output  DATA_WIDTH  read data; 0 for writes and timeouts
rsp_err  output  1  pslverr seen or timeout
rsp_timeout  output  1  watchdog abort
psel  output  1  APB select
penable  output  1  APB enable
pwrite  output  1  APB write strobe
paddr  output  ADDR_WIDTH  APB address
pwdata  output  DATA_WIDTH  APB write data
prdata  input  DATA_WIDTH  APB read data
pready  input  1  slave ready
pslverr  input  1  slave error

Behaviour:
- Reset (presetn=0, asynchronous) drives the following to 0: all outputs, the FSM (to IDLE), and the watchdog counter. This takes effect immediately, including mid-transfer: psel/penable drop and no response is produced for the aborted command.
- FSM states are IDLE, SETUP, ACCESS and RESP.
- cmd_ready = (state==IDLE) && pclken, purely combinational from state and pclken. No other combinational paths to outputs.
- IDLE: on cmd_valid && cmd_ready, register cmd_write/cmd_addr/cmd_wdata onto pwrite/paddr/pwdata; go to SETUP.
- SETUP: psel=1, penable=0 for exactly one enabled cycle, then ACCESS.
- ACCESS: psel=1, penable=1. The watchdog counter clears on entry and increments each pclken cycle with pready=0.
  - On pclken && pready: capture prdata into rsp_rdata (reads only; writes give 0), pslverr into rsp_err, rsp_timeout=0. Deassert psel/penable; go to RESP.
  - Otherwise, if TIMEOUT_CYCLES!=0 and the counter reaches TIMEOUT_CYCLES: set rsp_err=1, rsp_timeout=1, rsp_rdata=0. Deassert psel/penable; go to RESP.
  - pready takes priority when pready and timeout occur in the same cycle.
- RESP: rsp_valid=1 with rsp_* held stable until rsp_ready; then rsp_valid=0 and go to IDLE.
  - This transition does not depend on pclken.
  - rsp_* fields keep their values after handshake.
- Minimum command-accept to rsp_valid latency is 3 enabled cycles (SETUP, ACCESS with pready, RESP). Back-to-back commands have at least one IDLE cycle between transfers, so psel deasserts between transfers.
- paddr/pwdata/pwrite are stable from SETUP through end of ACCESS and hold their last value while idle.
- pclken=0 freezes IDLE/SETUP/ACCESS state, the outputs and the watchdog counter. pready/pslverr sampled while pclken=0 are ignored.
- Only one transfer is outstanding at a time; no command is accepted before the previous response handshake completes.

Test Plan:
- Write addr 0x0000_0010, data 0xDEAD_BEEF, pready=1 in ACCESS -> psel high for 2 cycles, penable high for 1; rsp_valid 3 cycles after accept; rsp_err=0, rsp_rdata=0.
- Read addr 0x24 with pready low for 3 ACCESS cycles, prdata=0x1234_5678 → penable high 4 cycles with paddr stable; rsp_rdata=0x1234_5678, rsp_err=0.
- Read with pslverr=1 at pready → rsp_err=1, rsp_timeout=0; a second command is accepted only after rsp_ready.
- TIMEOUT_CYCLES=8, pready held 0 → abort after 8 ACCESS cycles; psel=0; rsp_err=1, rsp_timeout=1, rsp_rdata=0. Repeat with pready=1 on cycle 8 → normal completion.
- rsp_ready held 0 for 5 cycles with cmd_valid high → cmd_ready stays 0 and rsp_* stay stable. pclken pulsing 1-in-3 → SETUP/ACCESS advance only on enabled cycles.
- presetn asserted during ACCESS → psel/penable/rsp_valid go to 0 immediately. After release, the FSM is in IDLE and cmd_ready=1 on the next cycle with pclken=1.

Source files
------------

// File: rtl/apb_cmd_master_if.sv
// Command, response and APB pin bundle for apb_cmd_master.
// The master modport is the view of apb_cmd_master itself.
// The slave modport is the view of the environment: the command source,
// the response sink and the APB completer.
interface apb_cmd_master_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    // Command port
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [DATA_WIDTH-1:0] cmd_wdata;

    // Response port
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_rdata;
    logic                  rsp_err;
    logic                  rsp_timeout;

    // APB pins
    logic                  psel;
    logic                  penable;
    logic                  pwrite;
    logic [ADDR_WIDTH-1:0] paddr;
    logic [DATA_WIDTH-1:0] pwdata;
    logic [DATA_WIDTH-1:0] prdata;
    logic                  pready;
    logic                  pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  rsp_ready,
        input  prdata, pready, pslverr,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        output psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output rsp_ready,
        output prdata, pready, pslverr,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err, rsp_timeout,
        input  psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/apb_cmd_master.sv
// APB command master: runs each accepted register command as one APB
// SETUP/ACCESS transfer.  It honours PREADY wait states, and a watchdog
// aborts a transfer that stalls too long.  It returns exactly one
// response per command.  Only one transfer is in flight at a time.
// All APB-side progress is gated by pclken.  The response handshake is not
// gated by pclken.
module apb_cmd_master #(
    parameter int ADDR_WIDTH     = 32,
    parameter int DATA_WIDTH     = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                  pclk,
    input  logic                  presetn,
    input  logic                  pclken,
    apb_cmd_master_if.master      bus
);

    // Watchdog counter is wide enough to hold TIMEOUT_CYCLES itself.
    // It is at least 1 bit wide so that a disabled watchdog still elaborates.
    localparam int WDOG_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(TIMEOUT_CYCLES);
    localparam logic [WDOG_W-1:0] WDOG_ONE   = WDOG_W'(1);
    localparam bit                WDOG_EN    = (TIMEOUT_CYCLES != 32'sd0);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    state_t                r_state;
    logic [WDOG_W-1:0]     r_wdog;
    logic                  r_psel;
    logic                  r_penable;
    logic                  r_pwrite;
    logic [ADDR_WIDTH-1:0] r_paddr;
    logic [DATA_WIDTH-1:0] r_pwdata;
    logic                  r_rsp_valid;
    logic [DATA_WIDTH-1:0] r_rsp_rdata;
    logic                  r_rsp_err;
    logic                  r_rsp_timeout;

    logic                  w_cmd_ready;
    logic [WDOG_W-1:0]     w_wdog_next;
    logic                  w_wdog_expire;

    // cmd_ready is the only combinational output.  The APB-side state can
    // only take a command on an enabled cycle.
    assign w_cmd_ready   = (r_state == ST_IDLE) && pclken;

    // The count this cycle would reach decides the abort, so the transfer
    // ends on exactly the TIMEOUT_CYCLES-th stalled ACCESS cycle.
    assign w_wdog_next   = r_wdog + WDOG_ONE;
    assign w_wdog_expire = WDOG_EN && (w_wdog_next == WDOG_LIMIT);

    assign bus.cmd_ready   = w_cmd_ready;
    assign bus.psel        = r_psel;
    assign bus.penable     = r_penable;
    assign bus.pwrite      = r_pwrite;
    assign bus.paddr       = r_paddr;
    assign bus.pwdata      = r_pwdata;
    assign bus.rsp_valid   = r_rsp_valid;
    assign bus.rsp_rdata   = r_rsp_rdata;
    assign bus.rsp_err     = r_rsp_err;
    assign bus.rsp_timeout = r_rsp_timeout;

    // Transfer FSM with registered APB and response outputs.
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            r_state       <= ST_IDLE;
            r_wdog        <= {WDOG_W{1'b0}};
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= {ADDR_WIDTH{1'b0}};
            r_pwdata      <= {DATA_WIDTH{1'b0}};
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= {DATA_WIDTH{1'b0}};
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // The address, data and direction stay on the bus after
                    // a transfer until the next command replaces them.
                    if (w_cmd_ready && bus.cmd_valid) begin
                        r_pwrite  <= bus.cmd_write;
                        r_paddr   <= bus.cmd_addr;
                        r_pwdata  <= bus.cmd_wdata;
                        r_psel    <= 1'b1;
                        r_penable <= 1'b0;
                        r_state   <= ST_SETUP;
                    end
                end

                ST_SETUP: begin
                    if (pclken) begin
                        r_penable <= 1'b1;
                        r_wdog    <= {WDOG_W{1'b0}};
                        r_state   <= ST_ACCESS;
                    end
                end

                ST_ACCESS: begin
                    if (pclken) begin
                        // If pready and the timeout arrive in the same cycle,
                        // pready wins.
                        if (bus.pready) begin
                            r_rsp_rdata   <= r_pwrite ? {DATA_WIDTH{1'b0}} : bus.prdata;
                            r_rsp_err     <= bus.pslverr;
                            r_rsp_timeout <= 1'b0;
                            r_psel        <= 1'b0;
                            r_penable     <= 1'b0;
                            r_rsp_valid   <= 1'b1;
                            r_state       <= ST_RESP;
                        end else if (w_wdog_expire) begin
                            r_rsp_rdata   <= {DATA_WIDTH{1'b0}};
                            r_rsp_err     <= 1'b1;
                            r_rsp_timeout <= 1'b1;
                            r_psel        <= 1'b0;
                            r_penable     <= 1'b0;
                            r_rsp_valid   <= 1'b1;
                            r_state       <= ST_RESP;
                        end else if (WDOG_EN) begin
                            r_wdog        <= w_wdog_next;
                        end else begin
                            r_wdog        <= r_wdog;
                        end
                    end
                end

                ST_RESP: begin
                    // The response sink is not on the APB clock enable.  The
                    // rsp_* fields keep their values after the handshake.
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_state     <= ST_IDLE;
                    end
                end

                default: begin
                    r_psel      <= 1'b0;
                    r_penable   <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Self-checking bench for apb_cmd_master.  The bench plays the command
// source, the response sink and the APB completer.  For each command, a
// reference model predicts the transfer from a few values: the direction,
// the completer's wait states, its error flag and the timeout limit.  The
// model gives the APB activity, the latency and the response.
module tb_apb_cmd_master;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int TO = 8;

    logic pclk = 1'b0;
    logic presetn;
    logic pclken;

    int n_vec = 0;
    int n_bad = 0;
    int en_mode = 0;
    int en_ph = 0;

    apb_cmd_master_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    apb_cmd_master #(
        .ADDR_WIDTH    (AW),
        .DATA_WIDTH    (DW),
        .TIMEOUT_CYCLES(TO)
    ) dut (
        .pclk   (pclk),
        .presetn(presetn),
        .pclken (pclken),
        .bus    (bus.master)
    );

    always #5 pclk = ~pclk;

    // Single comparison point: counts the comparison and reports a miscompare.
    task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Clock-enable pattern: 0 = always on, 1 = one cycle in three, else random.
    task automatic drive_en();
        case (en_mode)
            0: pclken = 1'b1;
            1: begin
                pclken = (en_ph == 0);
                en_ph  = (en_ph + 1) % 3;
            end
            default: pclken = 1'($urandom_range(0, 1));
        endcase
    endtask

    task automatic idle_noise();
        bus.pready  = 1'($urandom_range(0, 1));
        bus.pslverr = 1'($urandom_range(0, 1));
        bus.prdata  = $urandom;
    endtask

    // One command end to end.  rdy_dly is the number of enabled ACCESS cycles
    // that the completer stalls before it asserts pready.
    task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rdata, input logic err, input int rdy_dly,
                          input int rsp_hold, input string tag);
        logic        to_exp, exp_err, accepted, got_rsp;
        logic [31:0] exp_rdata, s_rdata;
        logic        s_err, s_to;
        int          n_acc, en_edges, psel_en, pen_en, acc_cnt, bus_bad, rdy_bad, stab_bad;

        // Reference model.
        to_exp    = (rdy_dly + 1 > TO);
        n_acc     = to_exp ? TO : rdy_dly + 1;
        exp_rdata = (wr || to_exp) ? 32'h0 : rdata;
        exp_err   = to_exp ? 1'b1 : err;

        accepted = 1'b0;
        for (int i = 0; i < 60 && !accepted; i++) begin
            @(negedge pclk);
            bus.cmd_valid = 1'b1;
            bus.cmd_write = wr;
            bus.cmd_addr  = addr;
            bus.cmd_wdata = wdata;
            bus.rsp_ready = 1'b0;
            idle_noise();
            drive_en();
            #1;
            if (bus.cmd_ready) accepted = 1'b1;
        end
        chk_eq({tag, "/accepted"}, 64'(accepted), 64'd1);
        if (!accepted) begin
            bus.cmd_valid = 1'b0;
            return;
        end

        en_edges = 0; psel_en = 0; pen_en = 0; acc_cnt = 0;
        bus_bad = 0; rdy_bad = 0; stab_bad = 0; got_rsp = 1'b0;
        for (int g = 0; g < 400 && !got_rsp; g++) begin
            @(negedge pclk);
            if (bus.rsp_valid) begin
                got_rsp = 1'b1;
            end else begin
                if (bus.psel && (bus.paddr !== addr || bus.pwrite !== wr || bus.pwdata !== wdata))
                    bus_bad++;
                if (bus.penable && !bus.psel) bus_bad++;
                bus.cmd_valid = 1'($urandom_range(0, 1));
                bus.cmd_addr  = $urandom;
                bus.cmd_wdata = $urandom;
                bus.cmd_write = 1'($urandom_range(0, 1));
                drive_en();
                if (bus.penable && pclken) begin
                    bus.pready  = (acc_cnt == rdy_dly);
                    bus.pslverr = bus.pready ? err : 1'($urandom_range(0, 1));
                    bus.prdata  = bus.pready ? rdata : $urandom;
                    acc_cnt++;
                end else begin
                    idle_noise();
                end
                if (pclken) en_edges++;
                if (pclken && bus.psel) psel_en++;
                if (pclken && bus.penable) pen_en++;
                #1;
                if (bus.cmd_ready) rdy_bad++;
            end
        end
        chk_eq({tag, "/rsp_seen"}, 64'(got_rsp), 64'd1);
        chk_eq({tag, "/latency"}, 64'(en_edges), 64'(1 + n_acc));
        chk_eq({tag, "/psel_cycles"}, 64'(psel_en), 64'(1 + n_acc));
        chk_eq({tag, "/penable_cycles"}, 64'(pen_en), 64'(n_acc));
        chk_eq({tag, "/bus_stable"}, 64'(bus_bad), 64'd0);
        chk_eq({tag, "/psel_in_resp"}, {63'd0, bus.psel | bus.penable}, 64'd0);
        chk_eq({tag, "/rsp_rdata"}, 64'(bus.rsp_rdata), 64'(exp_rdata));
        chk_eq({tag, "/rsp_err"}, 64'(bus.rsp_err), 64'(exp_err));
        chk_eq({tag, "/rsp_timeout"}, 64'(bus.rsp_timeout), 64'(to_exp));

        s_rdata = bus.rsp_rdata; s_err = bus.rsp_err; s_to = bus.rsp_timeout;
        for (int h = 0; h < rsp_hold; h++) begin
            bus.rsp_ready = 1'b0;
            bus.cmd_valid = 1'b1;
            drive_en();
            idle_noise();
            #1;
            if (bus.cmd_ready) rdy_bad++;
            @(negedge pclk);
            if (!bus.rsp_valid || bus.psel || bus.rsp_rdata !== s_rdata ||
                bus.rsp_err !== s_err || bus.rsp_timeout !== s_to)
                stab_bad++;
        end
        chk_eq({tag, "/cmd_blocked"}, 64'(rdy_bad), 64'd0);
        chk_eq({tag, "/rsp_stable"}, 64'(stab_bad), 64'd0);

        bus.rsp_ready = 1'b1;
        bus.cmd_valid = 1'b0;
        drive_en();
        @(negedge pclk);
        bus.rsp_ready = 1'b0;
        chk_eq({tag, "/rsp_dropped"}, 64'(bus.rsp_valid), 64'd0);
        chk_eq({tag, "/rsp_held"}, {29'd0, bus.rsp_timeout, bus.rsp_err, bus.rsp_rdata},
               {29'd0, s_to, s_err, s_rdata});
    endtask

    // Reset asserted while the transfer is in ACCESS.
    task automatic reset_in_access();
        int seen;
        en_mode = 0;
        @(negedge pclk);
        bus.cmd_valid = 1'b1; bus.cmd_write = 1'b0;
        bus.cmd_addr = 32'h0000_0040; bus.cmd_wdata = 32'h0;
        bus.pready = 1'b0; pclken = 1'b1;
        seen = 0;
        for (int i = 0; i < 10 && seen == 0; i++) begin
            @(negedge pclk);
            bus.cmd_valid = 1'b0;
            bus.pready = 1'b0;
            if (bus.penable) seen = 1;
        end
        chk_eq("rst/in_access", 64'(seen), 64'd1);
        presetn = 1'b0;
        pclken  = 1'b0;
        #1;
        chk_eq("rst/apb_low", {62'd0, bus.psel, bus.penable}, 64'd0);
        chk_eq("rst/rsp_low", 64'(bus.rsp_valid), 64'd0);
        chk_eq("rst/paddr", 64'(bus.paddr), 64'd0);
        chk_eq("rst/cmd_ready", 64'(bus.cmd_ready), 64'd0);
        @(negedge pclk);
        presetn = 1'b1;
        @(negedge pclk);
        pclken = 1'b1;
        #1;
        chk_eq("rst/ready_after", 64'(bus.cmd_ready), 64'd1);
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge pclk);
            if (bus.rsp_valid || bus.psel) seen++;
        end
        chk_eq("rst/no_rsp", 64'(seen), 64'd0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: observed running expected finished");
        $fatal(1);
    end

    initial begin
        presetn = 1'b0;
        pclken  = 1'b0;
        bus.cmd_valid = 1'b0; bus.cmd_write = 1'b0;
        bus.cmd_addr = 32'h0; bus.cmd_wdata = 32'h0;
        bus.rsp_ready = 1'b0; bus.prdata = 32'h0;
        bus.pready = 1'b0; bus.pslverr = 1'b0;
        #23;
        chk_eq("reset/apb", {27'd0, bus.psel, bus.penable, bus.pwrite, bus.paddr, 2'd0}, 64'd0);
        chk_eq("reset/pwdata", 64'(bus.pwdata), 64'd0);
        chk_eq("reset/rsp", {29'd0, bus.rsp_valid, bus.rsp_err, bus.rsp_timeout, bus.rsp_rdata}, 64'd0);
        chk_eq("reset/cmd_ready", 64'(bus.cmd_ready), 64'd0);
        @(negedge pclk);
        presetn = 1'b1;

        en_mode = 0;
        do_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 1'b0, 0, 0, "wr_fast");
        do_txn(1'b0, 32'h0000_0024, 32'h0, 32'h1234_5678, 1'b0, 3, 1, "rd_wait3");
        do_txn(1'b0, 32'h0000_0030, 32'h0, 32'hCAFE_0001, 1'b1, 0, 5, "rd_slverr");
        do_txn(1'b0, 32'h0000_0044, 32'h0, 32'hAAAA_5555, 1'b0, 100, 0, "rd_timeout");
        do_txn(1'b0, 32'h0000_0048, 32'h0, 32'h5A5A_A5A5, 1'b0, TO - 1, 0, "rd_ready_at_limit");
        do_txn(1'b1, 32'h0000_004C, 32'h0BAD_F00D, 32'hFFFF_FFFF, 1'b0, 100, 1, "wr_timeout");
        en_mode = 1;
        do_txn(1'b1, 32'h0000_0050, 32'h0102_0304, 32'h0, 1'b0, 2, 2, "wr_en_1of3");
        do_txn(1'b0, 32'h0000_0054, 32'h0, 32'h8765_4321, 1'b0, 1, 0, "rd_en_1of3");

        reset_in_access();

        for (int t = 0; t < 40; t++) begin
            en_mode = $urandom_range(0, 2);
            do_txn(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom,
                   1'($urandom_range(0, 1)), $urandom_range(0, 10),
                   $urandom_range(0, 3), "rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
